// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
// Byte-wide UART transmitter. It accepts one byte per tx_valid/tx_ready
// handshake. The byte goes out on TXD as a start bit, then 8 data bits
// LSB-first, then an optional parity bit, then 1 or 2 stop bits.
// TXD, tx_ready and state_mon all come straight from flops, so the pin never
// sees a combinational glitch and no input reaches an output in the same cycle.
module uart_tx_serializer #(
  parameter int CLK_DIV   = 434,  // CLK cycles per bit, 2..65535
  parameter int PARITY    = 0,    // 0 = none, 1 = even, 2 = odd
  parameter int STOP_BITS = 1     // 1 or 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       TXD,
  output logic [2:0] state_mon
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);
  localparam bit          HAS_PAR   = (PARITY != 0);

  state_t      state_reg;
  logic [15:0] div_reg;
  logic [2:0]  bit_cnt_reg;
  logic [7:0]  shift_reg;
  logic        parity_reg;
  logic        txd_reg;
  logic        tx_ready_reg;

  // The parity of tx_data is computed on the accept edge as an XOR chain.
  // The chain is seeded with 1 for odd parity, which inverts the even result.
  logic [8:0] par_chain;
  logic       parity_next;

  assign par_chain[0] = (PARITY == 2);

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_par
      assign par_chain[gi+1] = par_chain[gi] ^ tx_data[gi];
    end
  endgenerate

  assign parity_next = par_chain[8];

  // End of the current bit period. Every non-idle state lasts exactly CLK_DIV cycles.
  logic bit_tick;
  assign bit_tick = (div_reg == DIV_LAST);

  // Frame sequencer. It owns every output flop.
  // In the stop state, bit_cnt_reg counts the stop bits, so the 16-bit divider
  // never has to reach STOP_BITS*CLK_DIV.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg    <= ST_IDLE;
      div_reg      <= 16'd0;
      bit_cnt_reg  <= 3'd0;
      shift_reg    <= 8'd0;
      parity_reg   <= 1'b0;
      txd_reg      <= 1'b1;
      tx_ready_reg <= 1'b1;
    end else begin
      if (state_reg != ST_IDLE) begin
        div_reg <= bit_tick ? 16'd0 : div_reg + 16'd1;
      end

      case (state_reg)
        ST_IDLE: begin
          if (tx_valid && tx_ready_reg) begin
            shift_reg    <= tx_data;
            parity_reg   <= parity_next;
            tx_ready_reg <= 1'b0;
            txd_reg      <= 1'b0;
            div_reg      <= 16'd0;
            bit_cnt_reg  <= 3'd0;
            state_reg    <= ST_START;
          end
        end

        ST_START: begin
          if (bit_tick) begin
            txd_reg     <= shift_reg[0];
            bit_cnt_reg <= 3'd0;
            state_reg   <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (bit_tick) begin
            if (bit_cnt_reg == 3'd7) begin
              bit_cnt_reg <= 3'd0;
              if (HAS_PAR) begin
                txd_reg   <= parity_reg;
                state_reg <= ST_PARITY;
              end else begin
                txd_reg   <= 1'b1;
                state_reg <= ST_STOP;
              end
            end else begin
              shift_reg   <= {1'b0, shift_reg[7:1]};
              txd_reg     <= shift_reg[1];
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end
          end
        end

        ST_PARITY: begin
          if (bit_tick) begin
            txd_reg     <= 1'b1;
            bit_cnt_reg <= 3'd0;
            state_reg   <= ST_STOP;
          end
        end

        ST_STOP: begin
          if (bit_tick) begin
            if (bit_cnt_reg == STOP_LAST) begin
              bit_cnt_reg  <= 3'd0;
              tx_ready_reg <= 1'b1;
              state_reg    <= ST_IDLE;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end
          end
        end

        default: begin
          state_reg    <= ST_IDLE;
          txd_reg      <= 1'b1;
          tx_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign TXD       = txd_reg;
  assign tx_ready  = tx_ready_reg;
  assign state_mon = state_reg;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Testbench for uart_tx_serializer.
// Four copies of the design run at CLK_DIV=4:
//   u0: no parity, 1 stop bit
//   u1: even parity
//   u2: odd parity
//   u3: no parity, 2 stop bits
// The expected line waveform is built from the frame rules: one slot per bit,
// each slot CLK_DIV cycles long.
module tb_uart_tx_serializer;

  localparam int CDIV = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid [0:3];
  logic       txd      [0:3];
  logic       rdy      [0:3];
  logic [2:0] smon     [0:3];

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  uart_tx_serializer #(.CLK_DIV(CDIV), .PARITY(0), .STOP_BITS(1)) u0 (
    .CLK(CLK), .RST(RST), .tx_data(tx_data), .tx_valid(tx_valid[0]),
    .tx_ready(rdy[0]), .TXD(txd[0]), .state_mon(smon[0]));
  uart_tx_serializer #(.CLK_DIV(CDIV), .PARITY(1), .STOP_BITS(1)) u1 (
    .CLK(CLK), .RST(RST), .tx_data(tx_data), .tx_valid(tx_valid[1]),
    .tx_ready(rdy[1]), .TXD(txd[1]), .state_mon(smon[1]));
  uart_tx_serializer #(.CLK_DIV(CDIV), .PARITY(2), .STOP_BITS(1)) u2 (
    .CLK(CLK), .RST(RST), .tx_data(tx_data), .tx_valid(tx_valid[2]),
    .tx_ready(rdy[2]), .TXD(txd[2]), .state_mon(smon[2]));
  uart_tx_serializer #(.CLK_DIV(CDIV), .PARITY(0), .STOP_BITS(2)) u3 (
    .CLK(CLK), .RST(RST), .tx_data(tx_data), .tx_valid(tx_valid[3]),
    .tx_ready(rdy[3]), .TXD(txd[3]), .state_mon(smon[3]));

  // ---------------- reference model ----------------
  function automatic int par_of(input int k);
    return (k == 1) ? 1 : (k == 2) ? 2 : 0;
  endfunction

  function automatic int stop_of(input int k);
    return (k == 3) ? 2 : 1;
  endfunction

  function automatic int frame_slots(input int k);
    return 10 + ((par_of(k) != 0) ? 1 : 0) + stop_of(k) - 1;
  endfunction

  // Expected TXD i cycles after the accept edge.
  function automatic logic model_txd(input int k, input logic [7:0] d, input int i);
    int s;
    s = i / CDIV;
    if (s == 0) return 1'b0;
    if (s <= 8) return d[s-1];
    if (par_of(k) != 0 && s == 9) return (par_of(k) == 1) ? (^d) : ~(^d);
    return 1'b1;
  endfunction

  // Expected tx_ready i cycles after the accept edge.
  function automatic logic model_rdy(input int k, input int i);
    return logic'(i >= frame_slots(k) * CDIV);
  endfunction

  // ---------------- stimulus / capture ----------------
  logic       cap_txd [0:255];
  logic       cap_rdy [0:255];
  logic [2:0] cap_st  [0:255];
  logic       rec_q[$];

  // Pulse tx_valid for one cycle, then record ncyc cycles of outputs.
  // Sample 0 is taken half a cycle after the accept edge.
  // If busy_at >= 0, a second tx_valid pulse is applied at that sample index.
  task automatic send_capture(input int k, input logic [7:0] d, input int ncyc,
                              input int busy_at, input logic [7:0] busy_d);
    @(negedge CLK);
    tx_data     = d;
    tx_valid[k] = 1'b1;
    @(negedge CLK);
    tx_valid[k] = 1'b0;
    tx_data     = 8'($urandom);
    for (int i = 0; i < ncyc; i++) begin
      cap_txd[i] = txd[k];
      cap_rdy[i] = rdy[k];
      cap_st[i]  = smon[k];
      tx_valid[k] = (i == busy_at);
      if (i == busy_at) tx_data = busy_d;
      @(negedge CLK);
    end
    tx_valid[k] = 1'b0;
    $display("[TB] u%0d frame 0x%02h captured (%0d cycles)", k, d, ncyc);
  endtask

  // Record u0's TXD for one cycle, then advance to the next falling edge.
  task automatic tick_rec();
    rec_q.push_back(txd[0]);
    @(negedge CLK);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 RST = 1'b0;
    #2;
    tests++;
    if ({txd[0], rdy[0], smon[0]} !== {1'b1, 1'b1, 3'd0}) begin
      fails++;
      $display("FAIL reset_assert: txd=%b rdy=%b st=%0d, want 1 1 0",
               txd[0], rdy[0], smon[0]);
    end
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      tests++;
      if ({txd[0], rdy[0], smon[0], txd[1], rdy[1], txd[2], rdy[2], txd[3], rdy[3]}
          !== {1'b1, 1'b1, 3'd0, 6'b111111}) begin
        fails++;
        $display("FAIL idle cyc %0d: u0 txd=%b rdy=%b st=%0d, want 1 1 0",
                 c, txd[0], rdy[0], smon[0]);
      end
    end
  endtask

  task automatic test_a5();
    logic [9:0] exp_bits;
    int low;
    exp_bits = 10'b1101001010;
    send_capture(0, 8'hA5, 48, -1, 8'h00);
    low = 0;
    for (int i = 0; i < 48; i++) if (cap_rdy[i] === 1'b0) low++;
    tests++;
    if (low != 40 || cap_rdy[0] !== 1'b0 || cap_rdy[40] !== 1'b1) begin
      fails++;
      $display("FAIL a5_ready: low=%0d rdy0=%b rdy40=%b, want 40 0 1",
               low, cap_rdy[0], cap_rdy[40]);
    end
    for (int s = 0; s < 10; s++) begin
      for (int j = 0; j < CDIV; j++) begin
        tests++;
        if (cap_txd[s*CDIV+j] !== exp_bits[s]) begin
          fails++;
          $display("FAIL a5_slot %0d cyc %0d: txd=%b want %b",
                   s, j, cap_txd[s*CDIV+j], exp_bits[s]);
        end
      end
    end
    tests++;
    if ({cap_st[0], cap_st[4], cap_st[36], cap_st[40]} !== {3'd1, 3'd2, 3'd4, 3'd0}) begin
      fails++;
      $display("FAIL a5_state: %0d %0d %0d %0d want 1 2 4 0",
               cap_st[0], cap_st[4], cap_st[36], cap_st[40]);
    end
  endtask

  task automatic test_parity();
    int low;
    send_capture(1, 8'h07, 48, -1, 8'h00);
    low = 0;
    for (int i = 0; i < 48; i++) if (cap_rdy[i] === 1'b0) low++;
    tests++;
    if (cap_txd[38] !== 1'b1 || cap_st[38] !== 3'd3) begin
      fails++;
      $display("FAIL even_parity: slot=%b st=%0d want 1 3", cap_txd[38], cap_st[38]);
    end
    tests++;
    if (low != 44 || cap_rdy[44] !== 1'b1) begin
      fails++;
      $display("FAIL even_len: low=%0d rdy44=%b want 44 1", low, cap_rdy[44]);
    end
    send_capture(2, 8'h07, 48, -1, 8'h00);
    low = 0;
    for (int i = 0; i < 48; i++) if (cap_rdy[i] === 1'b0) low++;
    tests++;
    if (cap_txd[37] !== 1'b0 || cap_txd[41] !== 1'b1) begin
      fails++;
      $display("FAIL odd_parity: slot=%b stop=%b want 0 1", cap_txd[37], cap_txd[41]);
    end
    tests++;
    if (low != 44) begin
      fails++;
      $display("FAIL odd_len: low=%0d want 44", low);
    end
  endtask

  task automatic test_stop2();
    int low;
    send_capture(3, 8'hFF, 48, -1, 8'h00);
    low = 0;
    for (int i = 0; i < 48; i++) if (cap_rdy[i] === 1'b0) low++;
    for (int i = 0; i < 44; i++) begin
      tests++;
      if (cap_txd[i] !== ((i < 4) ? 1'b0 : 1'b1)) begin
        fails++;
        $display("FAIL stop2_txd cyc %0d: txd=%b want %b", i, cap_txd[i], (i >= 4));
      end
    end
    tests++;
    if (low != 44 || cap_rdy[43] !== 1'b0 || cap_rdy[44] !== 1'b1 || cap_st[43] !== 3'd4) begin
      fails++;
      $display("FAIL stop2_len: low=%0d rdy43=%b rdy44=%b st43=%0d want 44 0 1 4",
               low, cap_rdy[43], cap_rdy[44], cap_st[43]);
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    int n;
    for (int k = 0; k < 4; k++) begin
      for (int t = 0; t < 6; t++) begin
        d = 8'($urandom);
        n = frame_slots(k) * CDIV + 3;
        send_capture(k, d, n, -1, 8'h00);
        for (int i = 0; i < n; i++) begin
          tests++;
          if ({cap_txd[i], cap_rdy[i]} !== {model_txd(k, d, i), model_rdy(k, i)}) begin
            fails++;
            $display("FAIL random u%0d byte %02h cyc %0d: txd=%b rdy=%b want %b %b",
                     k, d, i, cap_txd[i], cap_rdy[i], model_txd(k, d, i), model_rdy(k, i));
          end
        end
      end
    end
  endtask

  task automatic test_busy();
    send_capture(0, 8'h12, 64, 10, 8'h34);
    for (int i = 0; i < 64; i++) begin
      tests++;
      if ({cap_txd[i], cap_rdy[i]} !== {model_txd(0, 8'h12, i), model_rdy(0, i)}) begin
        fails++;
        $display("FAIL busy cyc %0d: txd=%b rdy=%b want %b %b", i, cap_txd[i],
                 cap_rdy[i], model_txd(0, 8'h12, i), model_rdy(0, i));
      end
    end
  endtask

  // Upstream word stage feeding u0. Each 16-bit word is sent low byte first.
  // When LAST_AND_ODD is set, only the low byte is sent.
  // After a byte is accepted, the next tx_valid arrives two cycles after
  // tx_ready rises.
  task automatic test_word_stream();
    logic [15:0] words [0:2];
    logic        lodd  [0:2];
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    logic [7:0]  b;
    int n;
    int i;
    words[0] = 16'h1234; lodd[0] = 1'b0;
    words[1] = 16'h56AB; lodd[1] = 1'b0;
    words[2] = 16'h00CD; lodd[2] = 1'b1;
    for (int w = 0; w < 3; w++) begin
      exp_q.push_back(words[w][7:0]);
      if (!lodd[w]) exp_q.push_back(words[w][15:8]);
    end
    rec_q.delete();
    @(negedge CLK);
    for (int q = 0; q < exp_q.size(); q++) begin
      tx_data     = exp_q[q];
      tx_valid[0] = 1'b1;
      @(negedge CLK);
      tx_valid[0] = 1'b0;
      tick_rec();
      n = 0;
      while (rdy[0] !== 1'b1 && n < 200) begin
        tick_rec();
        n++;
      end
      tests++;
      if (n >= 200) begin
        fails++;
        $display("FAIL stream_timeout byte %0d: rdy=%b want 1", q, rdy[0]);
      end
      tick_rec();
      $display("[TB] upstream byte 0x%02h sent", exp_q[q]);
    end
    repeat (8) tick_rec();
    // Decode the recorded line: find each start bit, then sample the middle of every slot.
    i = 0;
    while (i + 9 * CDIV + 2 < rec_q.size()) begin
      if (rec_q[i] === 1'b0) begin
        for (int bi = 0; bi < 8; bi++) b[bi] = rec_q[i + (bi + 1) * CDIV + 2];
        tests++;
        if (rec_q[i + 9 * CDIV + 2] !== 1'b1) begin
          fails++;
          $display("FAIL stream_stop at %0d: got %b want 1", i, rec_q[i + 9 * CDIV + 2]);
        end
        got_q.push_back(b);
        i += 10 * CDIV;
      end else begin
        i++;
      end
    end
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL stream_count: got %0d bytes want %0d", got_q.size(), exp_q.size());
    end
    for (int q = 0; q < exp_q.size() && q < got_q.size(); q++) begin
      tests++;
      if (got_q[q] !== exp_q[q]) begin
        fails++;
        $display("FAIL stream_byte %0d: got %02h want %02h", q, got_q[q], exp_q[q]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    @(negedge CLK);
    tx_data     = 8'h00;
    tx_valid[0] = 1'b1;
    tx_valid[3] = 1'b1;
    @(negedge CLK);
    tx_valid[0] = 1'b0;
    tx_valid[3] = 1'b0;
    repeat (14) @(negedge CLK);
    #1 RST = 1'b0;
    #2;
    tests++;
    if ({txd[0], rdy[0], smon[0], txd[3], rdy[3], smon[3]} !== {1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 3'd0}) begin
      fails++;
      $display("FAIL reset_mid: u0 txd=%b rdy=%b st=%0d u3 txd=%b rdy=%b st=%0d want 1 1 0",
               txd[0], rdy[0], smon[0], txd[3], rdy[3], smon[3]);
    end
    @(negedge CLK);
    RST = 1'b1;
    d = 8'($urandom);
    send_capture(0, d, 44, -1, 8'h00);
    for (int i = 0; i < 44; i++) begin
      tests++;
      if ({cap_txd[i], cap_rdy[i]} !== {model_txd(0, d, i), model_rdy(0, i)}) begin
        fails++;
        $display("FAIL after_reset byte %02h cyc %0d: txd=%b rdy=%b want %b %b",
                 d, i, cap_txd[i], cap_rdy[i], model_txd(0, d, i), model_rdy(0, i));
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) tx_valid[k] = 1'b0;
    test_reset();
    test_a5();
    test_parity();
    test_stop2();
    test_random();
    test_busy();
    test_word_stream();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
Byte-level UART transmitter that sits directly downstream of the 16-bit-word-to-byte output stage. It accepts one byte per tx_valid/tx_ready handshake and serializes it onto the TXD line as start bit, 8 data bits LSB-first, optional parity, and 1 or 2 stop bits. tx_ready tells the upstream stage when the next byte may be presented. The TXD pin leaves the board through this block.

Parameters:
CLK_DIV, 434, CLK cycles per bit (50 MHz / 115200); legal range 2..65535.
PARITY, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
CLK  input  1  system clock
RST  input  1  asynchronous, active-low reset
tx_data  input  8  byte to send; sampled only on the accept edge
tx_valid  input  1  single-cycle request from upstream; upstream holds tx_data stable during this cycle
tx_ready  output  1  1 = idle and able to accept a byte; registered
TXD  output  1  serial line; idle high; registered, glitch-free
state_mon  output  3  current FSM state, for debug

Behaviour:
- Reset (RST low, asynchronous): TXD=1, tx_ready=1, FSM=IDLE, bit counter=0, divider=0, shift register=0. Reset mid-frame aborts the frame and TXD returns high immediately, with no completion of stop bits.
- Accept: a posedge with tx_valid=1 and tx_ready=1. On that same edge:
  - latch tx_data into the shift register;
  - compute parity (even: XOR of data bits; odd: inverted);
  - drive tx_ready<=0 and TXD<=0;
  - enter START.
  tx_ready is therefore low in the cycle after the tx_valid pulse. The upstream stage relies on this: it samples tx_ready two cycles after tx_valid.
- tx_valid while tx_ready=0 is ignored. There is no queue and no error flag. tx_data changes outside the accept edge have no effect.
- FSM states: IDLE, START, DATA, PARITY, STOP. state_mon encodes them as 0..4.
  - Every non-IDLE state holds TXD for exactly CLK_DIV cycles. The divider counts 0..CLK_DIV-1, and the transition fires when divider==CLK_DIV-1.
  - START -> DATA: TXD<=shift[0].
  - DATA: shift right each bit period; after bit 7, go to PARITY if PARITY!=0, else to STOP. TXD<=parity bit or 1.
  - PARITY -> STOP: TXD<=1.
  - STOP: after STOP_BITS*CLK_DIV cycles, go to IDLE with tx_ready<=1 and TXD stays 1.
- Frame length: tx_ready low for exactly (10 + (PARITY!=0) + STOP_BITS - 1) * CLK_DIV cycles. With defaults this is 10*CLK_DIV.
- Back-to-back bytes:
  - the earliest next accept is the edge after tx_ready rises;
  - the extra idle-high gap on TXD equals the upstream latency, which is 2 cycles for the output stage;
  - the framing is still correct.
- Simultaneous tx_valid and frame completion on the same edge: the byte is not accepted, because tx_ready is still 0 at that edge. Upstream never does this.
- Divider width: 16 bits. Bit counter width: 3 bits; it wraps 7 -> 0 at the end of DATA.
- No combinational path from any input to any output.

Test Plan:
- Reset then idle, CLK_DIV=4, defaults: TXD=1 and tx_ready=1 for 100 cycles, state_mon=0.
- Send 0xA5, CLK_DIV=4, no parity, 1 stop:
  - tx_ready low the cycle after tx_valid, for exactly 40 cycles;
  - TXD in 4-cycle slots reads 0,1,0,1,0,0,1,0,1,1.
- Parity check, CLK_DIV=4:
  - PARITY=1, send 0x07: parity slot = 1 and tx_ready low for 44 cycles;
  - PARITY=2, send 0x07: parity slot = 0.
- STOP_BITS=2, send 0xFF: start slot 0, then 8 slots of 1, then stop high for 8 cycles; tx_ready low for 44 cycles total.
- Busy rejection: send 0x12, then pulse tx_valid with 0x34 during DATA. Only the 0x12 frame appears, and TXD returns to idle afterwards.
- Drive from the output word stage:
  - feed words 0x1234 and 0x56AB with LAST_AND_ODD=0, then 0x00CD with LAST_AND_ODD=1;
  - decoded byte stream 34,12,AB,56,CD;
  - assert RST mid-frame: TXD=1 and tx_ready=1 immediately, and the next frame after release is well-formed.
